// File: rtl/kernel_sequencer.sv
// ---------------------------------------------------------------------------
// kernel_sequencer
//
// Drives one shared array of 3*N kernel convolution units through a full
// image pass: a load sweep that streams every pixel of an N x N frame from a
// source memory into the array, a short settling gap, and a readout sweep
// that collects each pixel's result from its owning lane and writes it to a
// destination memory. The kernel units only act on alternate clocks, so each
// load address is held for 2 cycles and each readout address for 3 cycles.
//
// Optional build macro: SEQ_ZERO_CNT_EN adds the zero_cnt output, a count of
// readout writes whose data is zero.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   start     begin a pass (sampled only while idle)
//   busy      high from the cycle after start is accepted until done
//   done      one-cycle pulse at the end of a pass
//   src_rd    source read strobe; src_data is valid one cycle later
//   src_addr  source read address
//   src_data  source read data
//   k_we      kernel array write enable
//   k_addr    kernel array pixel position
//   k_data    kernel array write data
//   k_out     concatenated lane outputs, lane l at [l*pixelWidth +: pixelWidth]
//   dst_we    destination write strobe
//   dst_addr  destination address
//   dst_data  destination data
//   zero_cnt  (SEQ_ZERO_CNT_EN only) zero-valued destination writes this pass
// ---------------------------------------------------------------------------
module kernel_sequencer #(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      src_rd,
  output logic [bitSize:0]          src_addr,
  input  logic [pixelWidth-1:0]     src_data,
  output logic                      k_we,
  output logic [bitSize:0]          k_addr,
  output logic [pixelWidth-1:0]     k_data,
  input  logic [3*N*pixelWidth-1:0] k_out,
  output logic                      dst_we,
  output logic [bitSize:0]          dst_addr,
  output logic [pixelWidth-1:0]     dst_data
`ifdef SEQ_ZERO_CNT_EN
  ,
  output logic [bitSize+1:0]        zero_cnt
`endif
);

  localparam int LANES = 3 * N;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [bitSize:0] LAST  = (bitSize+1)'(N * N - 1);
  localparam logic [bitSize:0] NW    = (bitSize+1)'(N);
  localparam logic [bitSize:0] THREE = (bitSize+1)'(3);
  localparam logic [bitSize:0] ONE   = (bitSize+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, READ, FIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [bitSize:0]      cnt_q, cnt_d;
  logic                  tail_q, tail_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  src_rd_q, src_rd_d;
  logic [bitSize:0]      src_addr_q, src_addr_d;
  logic                  k_we_q, k_we_d;
  logic [bitSize:0]      k_addr_q, k_addr_d;
  logic [pixelWidth-1:0] k_data_q, k_data_d;
  logic                  dst_we_q, dst_we_d;
  logic [bitSize:0]      dst_addr_q, dst_addr_d;
  logic [pixelWidth-1:0] dst_data_q, dst_data_d;
`ifdef SEQ_ZERO_CNT_EN
  logic [bitSize+1:0]    zc_q, zc_d;
`endif

  // Lane view of the concatenated kernel outputs.
  logic [pixelWidth-1:0] lane_w [LANES];
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_w[gi] = k_out[gi*pixelWidth +: pixelWidth];
  end

  // Owning lane of the pixel currently being read: rows rotate through
  // three banks of N lanes each.
  logic [bitSize:0] row_w, col_w, rmod_w;
  logic [LW-1:0]    lane_sel_w;
  always_comb begin
    row_w      = cnt_q / NW;
    col_w      = cnt_q % NW;
    rmod_w     = row_w % THREE;
    lane_sel_w = LW'(rmod_w * NW + col_w);
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    src_rd_d   = 1'b0;
    src_addr_d = src_addr_q;
    k_we_d     = k_we_q;
    k_addr_d   = k_addr_q;
    k_data_d   = k_data_q;
    dst_we_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
`ifdef SEQ_ZERO_CNT_EN
    zc_d       = zc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          src_rd_d   = 1'b1;
          src_addr_d = '0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          phase_d    = 2'd0;
          tail_d     = 1'b0;
`ifdef SEQ_ZERO_CNT_EN
          zc_d       = '0;
`endif
        end
      end
      LOAD: begin
        // Phase 0 issues (or idles after) a source read; at the end of
        // phase 1 the returned pixel is captured into a new 2-cycle window
        // and the read for the following pixel is issued.
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          phase_d = 2'd0;
          if (tail_q) begin
            // Last window has had its two cycles; k_addr stays on the
            // final pixel through the gap.
            state_d = GAP;
            k_we_d  = 1'b0;
          end else begin
            k_we_d   = 1'b1;
            k_addr_d = cnt_q;
            k_data_d = src_data;
            if (cnt_q == LAST) begin
              tail_d = 1'b1;
            end else begin
              src_rd_d   = 1'b1;
              src_addr_d = cnt_q + ONE;
              cnt_d      = cnt_q + ONE;
            end
          end
        end
      end
      GAP: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          state_d  = READ;
          phase_d  = 2'd0;
          cnt_d    = '0;
          k_addr_d = '0;
        end
      end
      READ: begin
        // The lane has had two cycles to settle on k_addr before the result
        // is taken, so the write lands on the third cycle of the window.
        unique case (phase_q)
          2'd0: phase_d = 2'd1;
          2'd1: begin
            phase_d    = 2'd2;
            dst_we_d   = 1'b1;
            dst_addr_d = cnt_q;
            dst_data_d = lane_w[lane_sel_w];
`ifdef SEQ_ZERO_CNT_EN
            if (lane_w[lane_sel_w] == '0) zc_d = zc_q + (bitSize+2)'(1);
`endif
          end
          default: begin
            phase_d = 2'd0;
            if (cnt_q == LAST) begin
              state_d  = FIN;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              k_addr_d = '0;
            end else begin
              cnt_d    = cnt_q + ONE;
              k_addr_d = cnt_q + ONE;
            end
          end
        endcase
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      tail_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      k_we_q     <= 1'b0;
      k_addr_q   <= '0;
      k_data_q   <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
`ifdef SEQ_ZERO_CNT_EN
      zc_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      k_we_q     <= k_we_d;
      k_addr_q   <= k_addr_d;
      k_data_q   <= k_data_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
`ifdef SEQ_ZERO_CNT_EN
      zc_q       <= zc_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign src_rd   = src_rd_q;
  assign src_addr = src_addr_q;
  assign k_we     = k_we_q;
  assign k_addr   = k_addr_q;
  assign k_data   = k_data_q;
  assign dst_we   = dst_we_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
`ifdef SEQ_ZERO_CNT_EN
  assign zero_cnt = zc_q;
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kernel_sequencer
//
// Bench for kernel_sequencer with N=8. Around the DUT sit a registered source
// memory, a kernel array model (writes accepted on even-only or odd-only
// clocks, a cross-shaped erosion read out on the owning lane, distinctive
// junk on every other lane) and a monitor that records destination writes
// and window timing. Expected frames are written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_kernel_sequencer;

  localparam int N     = 8;
  localparam int BS    = 6;
  localparam int PW    = 8;
  localparam int LANES = 3 * N;
  localparam int NPIX  = N * N;
  localparam int LAT   = 5 * N * N + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start;
  logic              busy, done, src_rd, k_we, dst_we;
  logic [BS:0]       src_addr, k_addr, dst_addr;
  logic [PW-1:0]     src_data, k_data, dst_data;
  logic [LANES*PW-1:0] k_out;
`ifdef SEQ_ZERO_CNT_EN
  logic [BS+1:0]     zero_cnt;
`endif

  kernel_sequencer #(.N(N), .bitSize(BS), .pixelWidth(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data), .k_out(k_out),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data)
`ifdef SEQ_ZERO_CNT_EN
    , .zero_cnt(zero_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Source memory with one cycle of read latency.
  logic [7:0] smem [128];
  always @(posedge clk) if (src_rd) src_data <= smem[src_addr];

  // Kernel array model.
  logic [7:0] kmem [128];
  bit ktick = 1'b0;
  bit kphase = 1'b0;
  bit kclr = 1'b0;
  always @(posedge clk) begin
    ktick <= ~ktick;
    if (kclr) begin
      for (int i = 0; i < 128; i++) kmem[i] <= 8'hEE;
    end else if (ktick == kphase && k_we) begin
      kmem[k_addr] <= k_data;
    end
  end

  function automatic int lane_of(input int a);
    return ((a / N) % 3) * N + (a % N);
  endfunction

  function automatic logic [7:0] erode(input int a);
    logic [7:0] m;
    int r, c;
    if (a >= NPIX) return 8'h00;
    r = a / N;
    c = a % N;
    m = kmem[a];
    if (r > 0     && kmem[a-N] < m) m = kmem[a-N];
    if (r < N - 1 && kmem[a+N] < m) m = kmem[a+N];
    if (c > 0     && kmem[a-1] < m) m = kmem[a-1];
    if (c < N - 1 && kmem[a+1] < m) m = kmem[a+1];
    return m;
  endfunction

  int kl_w;
  always_comb begin
    k_out = '0;
    kl_w  = lane_of(int'(k_addr));
    for (int l = 0; l < LANES; l++) k_out[l*PW +: PW] = 8'hA0 + 8'(l);
    if (kl_w < LANES) k_out[kl_w*PW +: PW] = erode(int'(k_addr));
  end

  // Monitor: counts strobes, records destination writes, checks windows.
  bit clr = 1'b0;
  int src_rd_n, dst_we_n, done_n, done_edge, win_n;
  int load_viol, rd_viol, order_viol, run, hold, exp_addr;
  logic       prev_we;
  logic [BS:0] prev_addr;
  logic [7:0] prev_data;
  logic [7:0] dst_mem [128];
  always @(negedge clk) begin
    if (clr) begin
      src_rd_n = 0; dst_we_n = 0; done_n = 0; done_edge = 0; win_n = 0;
      load_viol = 0; rd_viol = 0; order_viol = 0; run = 0; hold = 0;
      exp_addr = 0;
      for (int i = 0; i < 128; i++) dst_mem[i] = 8'hEE;
    end else begin
      if (src_rd) src_rd_n++;
      if (k_we) begin
        if (prev_we && k_addr == prev_addr && k_data == prev_data) run++;
        else begin
          if (prev_we && run != 2) load_viol++;
          run = 1;
          win_n++;
        end
      end else if (prev_we && run != 2) load_viol++;
      if (!k_we && !prev_we && k_addr == prev_addr) hold++;
      else hold = 1;
      if (dst_we) begin
        dst_we_n++;
        if (hold != 3) rd_viol++;
        if (int'(dst_addr) != exp_addr) order_viol++;
        exp_addr++;
        dst_mem[dst_addr] = dst_data;
      end
      if (done) begin
        done_n++;
        done_edge = edge_n;
      end
    end
    prev_we   = k_we;
    prev_addr = k_addr;
    prev_data = k_data;
  end

  function automatic logic [7:0] grad_pix(input int a);
    return 8'(a * 3 + 1);
  endfunction

  // Erosion of an increasing ramp: the smallest cross neighbour is the one
  // above, else the one to the left, else the pixel itself.
  function automatic logic [7:0] grad_exp(input int a);
    if (a / N > 0) return grad_pix(a - N);
    if (a % N > 0) return grad_pix(a - 1);
    return grad_pix(a);
  endfunction

  task automatic fill_grad();
    for (int a = 0; a < 128; a++) smem[a] = (a < NPIX) ? grad_pix(a) : 8'h00;
  endtask

  task automatic prep();
    kclr = 1'b1;
    @(posedge clk);
    #1 kclr = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic run_pass(output bit to, output int lat);
    int st;
    prep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 st = edge_n;
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_n > 0) begin
        to = 1'b0;
        break;
      end
    end
    lat = done_edge - st;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3*(BS+1)+3*PW+5:0] outs;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    outs = {busy, done, src_rd, src_addr, k_we, k_addr, k_data, dst_we, dst_addr, dst_data};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
`ifdef SEQ_ZERO_CNT_EN
    total++;
    if (zero_cnt !== '0) begin
      bad++;
      $display("FAIL reset_zero_cnt got=%0d exp=0", zero_cnt);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: outputs=%h", outs);
  endtask

  task automatic test_uniform();
    bit to;
    int lat, errs;
    for (int a = 0; a < 128; a++) smem[a] = 8'h55;
    kphase = 1'b0;
    run_pass(to, lat);
    total++;
    if (to) begin bad++; $display("FAIL uniform_timeout got=none exp=done"); end
    total++;
    if (lat != LAT) begin bad++; $display("FAIL uniform_latency got=%0d exp=%0d", lat, LAT); end
    errs = 0;
    for (int a = 0; a < NPIX; a++) begin
      total++;
      if (dst_mem[a] !== 8'h55) begin
        bad++;
        errs++;
        $display("FAIL uniform_dst[%0d] got=%h exp=55", a, dst_mem[a]);
      end
    end
    $display("uniform: latency=%0d writes=%0d errors=%0d", lat, dst_we_n, errs);
  endtask

  task automatic test_single_pixel();
    bit to;
    int lat, nz;
    int probe [5] = '{27, 19, 26, 28, 35};
    for (int a = 0; a < 128; a++) smem[a] = 8'h00;
    smem[27] = 8'hFF;
    kphase = 1'b1;
    run_pass(to, lat);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout got=none exp=done"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dst_mem[probe[i]] !== 8'h00) begin
        bad++;
        $display("FAIL single_dst[%0d] got=%h exp=00", probe[i], dst_mem[probe[i]]);
      end
    end
    nz = 0;
    for (int a = 0; a < NPIX; a++) if (dst_mem[a] !== 8'h00) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL single_nonzero_count got=%0d exp=0", nz); end
`ifdef SEQ_ZERO_CNT_EN
    total++;
    if (zero_cnt !== 8'(NPIX)) begin
      bad++;
      $display("FAIL single_zero_cnt got=%0d exp=%0d", zero_cnt, NPIX);
    end
`endif
    $display("single_pixel: latency=%0d nonzero=%0d", lat, nz);
  endtask

  task automatic test_timing();
    bit to;
    int lat;
    fill_grad();
    kphase = 1'b0;
    run_pass(to, lat);
    total++;
    if (to) begin bad++; $display("FAIL timing_timeout got=none exp=done"); end
    total++;
    if (lat != LAT) begin bad++; $display("FAIL timing_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (src_rd_n != NPIX) begin bad++; $display("FAIL src_rd_count got=%0d exp=%0d", src_rd_n, NPIX); end
    total++;
    if (dst_we_n != NPIX) begin bad++; $display("FAIL dst_we_count got=%0d exp=%0d", dst_we_n, NPIX); end
    total++;
    if (win_n != NPIX) begin bad++; $display("FAIL load_windows got=%0d exp=%0d", win_n, NPIX); end
    total++;
    if (load_viol != 0) begin bad++; $display("FAIL load_window_len got=%0d exp=0", load_viol); end
    total++;
    if (rd_viol != 0) begin bad++; $display("FAIL read_window_len got=%0d exp=0", rd_viol); end
    total++;
    if (order_viol != 0) begin bad++; $display("FAIL dst_order got=%0d exp=0", order_viol); end
    total++;
    if (done_n != 1) begin bad++; $display("FAIL timing_done_pulses got=%0d exp=1", done_n); end
    for (int a = 0; a < NPIX; a++) begin
      total++;
      if (dst_mem[a] !== grad_exp(a)) begin
        bad++;
        $display("FAIL timing_dst[%0d] got=%h exp=%h", a, dst_mem[a], grad_exp(a));
      end
    end
    $display("timing: latency=%0d src_rd=%0d dst_we=%0d", lat, src_rd_n, dst_we_n);
  endtask

  task automatic test_phase();
    bit to;
    int lat, errs;
    fill_grad();
    kphase = 1'b1;
    run_pass(to, lat);
    total++;
    if (to) begin bad++; $display("FAIL phase_timeout got=none exp=done"); end
    errs = 0;
    for (int a = 0; a < NPIX; a++) begin
      total++;
      if (dst_mem[a] !== grad_exp(a)) begin
        bad++;
        errs++;
        $display("FAIL phase_dst[%0d] got=%h exp=%h", a, dst_mem[a], grad_exp(a));
      end
    end
    $display("phase_odd: latency=%0d errors=%0d", lat, errs);
  endtask

  task automatic test_start_hold();
    int st, lat1;
    bit seen;
    fill_grad();
    kphase = 1'b0;
    prep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 st = edge_n;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_n > 0) begin seen = 1'b1; break; end
    end
    lat1 = done_edge - st;
    repeat (10) @(negedge clk);
    total++;
    if (!seen) begin bad++; $display("FAIL hold_timeout got=none exp=done"); end
    total++;
    if (lat1 != LAT) begin bad++; $display("FAIL hold_latency got=%0d exp=%0d", lat1, LAT); end
    total++;
    if (done_n != 1) begin bad++; $display("FAIL hold_done_pulses got=%0d exp=1", done_n); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL hold_second_pass got=%b exp=1", busy); end
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_n > 1) break;
    end
    total++;
    if (done_n != 2) begin bad++; $display("FAIL hold_total_done got=%0d exp=2", done_n); end
    total++;
    if (done_edge - st != 2 * LAT + 2) begin
      bad++;
      $display("FAIL hold_second_done got=%0d exp=%0d", done_edge - st, 2 * LAT + 2);
    end
    @(negedge clk);
    $display("start_hold: first=%0d second=%0d", lat1, done_edge - st);
  endtask

  task automatic test_reset_mid();
    logic [3*(BS+1)+3*PW+5:0] outs;
    bit to;
    int lat;
    for (int a = 0; a < 128; a++) smem[a] = 8'h55;
    kphase = 1'b1;
    prep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 outs = {busy, done, src_rd, src_addr, k_we, k_addr, k_data, dst_we, dst_addr, dst_data};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (done_n != 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", done_n); end
    run_pass(to, lat);
    total++;
    if (to) begin bad++; $display("FAIL midreset_timeout got=none exp=done"); end
    total++;
    if (lat != LAT) begin bad++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (dst_we_n != NPIX) begin bad++; $display("FAIL midreset_writes got=%0d exp=%0d", dst_we_n, NPIX); end
    for (int a = 0; a < NPIX; a++) begin
      total++;
      if (dst_mem[a] !== 8'h55) begin
        bad++;
        $display("FAIL midreset_dst[%0d] got=%h exp=55", a, dst_mem[a]);
      end
    end
    $display("reset_mid: latency=%0d writes=%0d", lat, dst_we_n);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_uniform();
    test_single_pixel();
    test_timing();
    test_phase();
    test_start_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
